// File: rtl/fpu_pkg.sv
// Shared FPU definitions: canonical NaN, reduction FSM encoding and the
// binary32 unpack/classify helpers used by the min/max controller.
package fpu_pkg;

  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;
  localparam logic [7:0]  EXP_MAX   = 8'hFF;
  localparam int          QNAN_BIT  = 22;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FIRST = 2'd1,
    ST_ACCUM = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // mant carries the hidden bit in [23]
  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [23:0] mant;
    logic        is_nan;
  } fp_unpk_t;

  function automatic logic fp_is_nan(input logic [31:0] x);
    return (x[30:23] == EXP_MAX) && (x[22:0] != 23'h0);
  endfunction

  function automatic logic fp_is_snan(input logic [31:0] x);
    return fp_is_nan(x) && !x[QNAN_BIT];
  endfunction

  function automatic fp_unpk_t fp_unpack(input logic [31:0] x);
    fp_unpk_t u;
    u.sign   = x[31];
    u.exp    = x[30:23];
    u.mant   = {(x[30:23] != 8'h00), x[22:0]};
    u.is_nan = fp_is_nan(x);
    return u;
  endfunction

endpackage

// File: rtl/fpu_min_max.sv
// Combinational FMIN/FMAX datapath on unpacked binary32 operands.
// NaN loses to a number, -0 orders below +0, equal operands return A.
module fpu_min_max
  import fpu_pkg::*;
(
  input  logic        min_or_max,
  input  fp_unpk_t    a_i,
  input  fp_unpk_t    b_i,
  output logic [31:0] res_o
);

  function automatic logic fp_lt(input fp_unpk_t x, input fp_unpk_t y);
    logic [31:0] mag_x;
    logic [31:0] mag_y;
    mag_x = {x.exp, x.mant};
    mag_y = {y.exp, y.mant};
    if (x.sign != y.sign) begin
      return x.sign;
    end else if (!x.sign) begin
      return mag_x < mag_y;
    end else begin
      return mag_x > mag_y;
    end
  endfunction

  logic pick_b_s;

  // Select operand B only when it strictly wins the ordering
  always_comb begin
    pick_b_s = 1'b0;
    if (a_i.is_nan) begin
      pick_b_s = 1'b1;
    end else if (b_i.is_nan) begin
      pick_b_s = 1'b0;
    end else if (min_or_max) begin
      pick_b_s = fp_lt(a_i, b_i);
    end else begin
      pick_b_s = fp_lt(b_i, a_i);
    end
  end

  assign res_o = pick_b_s ? {b_i.sign, b_i.exp, b_i.mant[22:0]}
                          : {a_i.sign, a_i.exp, a_i.mant[22:0]};

endmodule

// File: rtl/fpu_minmax_reduce.sv
// Sequencer that folds a stream of binary32 elements into one FMIN/FMAX
// result through fpu_min_max, tracking sticky NV and a result handshake.
module fpu_minmax_reduce
  import fpu_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_op_i,
  input  logic [LEN_W-1:0] req_len_i,
  input  logic             elem_valid_i,
  output logic             elem_ready_o,
  input  logic [31:0]      elem_data_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [31:0]      res_data_o,
  output logic             res_nv_o,
  output logic             busy_o
);

  localparam logic [LEN_W-1:0] LEN_ZERO = '0;
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

  state_e           state_q, state_d;
  logic [31:0]      acc_q, acc_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             nv_q, nv_d;
  logic             op_q, op_d;
  logic             res_valid_q, res_valid_d;
  logic [31:0]      res_data_q, res_data_d;
  logic             res_nv_q, res_nv_d;

  logic             finish_s;
  logic             res_hs_s;
  logic [31:0]      mm_res_s;
  fp_unpk_t         acc_unpk_s;
  fp_unpk_t         elem_unpk_s;

  assign acc_unpk_s  = fp_unpack(acc_q);
  assign elem_unpk_s = fp_unpack(elem_data_i);
  assign res_hs_s    = (state_q == ST_DONE) && res_ready_i;

  fpu_min_max u_min_max (
    .min_or_max (op_q),
    .a_i        (acc_unpk_s),
    .b_i        (elem_unpk_s),
    .res_o      (mm_res_s)
  );

  // Next-state, accumulator, counter and sticky-flag logic
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    nv_d     = nv_q;
    op_d     = op_q;
    finish_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          op_d  = req_op_i;
          rem_d = req_len_i;
          nv_d  = 1'b0;
          if (req_len_i == LEN_ZERO) begin
            acc_d    = CANON_NAN;
            state_d  = ST_DONE;
            finish_s = 1'b1;
          end else begin
            state_d = ST_FIRST;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FIRST, ST_ACCUM: begin
        if (elem_valid_i) begin
          acc_d = (state_q == ST_FIRST) ? elem_data_i : mm_res_s;
          nv_d  = nv_q | fp_is_snan(elem_data_i);
          rem_d = rem_q - LEN_ONE;
          if (rem_q == LEN_ONE) begin
            state_d  = ST_DONE;
            finish_s = 1'b1;
          end else begin
            state_d = ST_ACCUM;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_DONE: begin
        if (res_ready_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Result registers load on the finishing transfer and clear on acceptance
  always_comb begin
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_nv_d    = res_nv_q;
    if (finish_s) begin
      res_valid_d = 1'b1;
      res_data_d  = fp_is_nan(acc_d) ? CANON_NAN : acc_d;
      res_nv_d    = nv_d;
    end else if (res_hs_s) begin
      res_valid_d = 1'b0;
      res_data_d  = 32'h0000_0000;
      res_nv_d    = 1'b0;
    end else begin
      res_valid_d = res_valid_q;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q     <= ST_IDLE;
      acc_q       <= 32'h0000_0000;
      rem_q       <= LEN_ZERO;
      nv_q        <= 1'b0;
      op_q        <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= 32'h0000_0000;
      res_nv_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      rem_q       <= rem_d;
      nv_q        <= nv_d;
      op_q        <= op_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_nv_q    <= res_nv_d;
    end
  end

  assign req_ready_o  = (state_q == ST_IDLE);
  assign elem_ready_o = (state_q == ST_FIRST) || (state_q == ST_ACCUM);
  assign busy_o       = (state_q != ST_IDLE);
  assign res_valid_o  = res_valid_q;
  assign res_data_o   = res_data_q;
  assign res_nv_o     = res_nv_q;

endmodule
